raw10_pixel_serializer: RTL and testbench

//  Downstream stage of the MIPI RAW10 unpacker. Buffers 40-bit 4-pixel groups in a small FIFO.

---
 rtl/raw10_pkg.sv | 20 ++
 rtl/raw10_grp_fifo.sv | 58 +++++
 rtl/raw10_pixel_serializer.sv | 124 ++++++++++++
 tb/tb_raw10_pixel_serializer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw10_pkg.sv
// Shared constants, types and helpers for the RAW10 pixel datapath.
//   RAW10_PIX_W  width of one RAW10 pixel
//   PIX_PER_GRP  pixels carried in one unpacked group
//   GRP_W        width of one group word
//   raw10_lane() selects pixel idx from a group; pixel 0 sits in the MSBs.
package raw10_pkg;

  localparam int unsigned RAW10_PIX_W = 10;
  localparam int unsigned PIX_PER_GRP = 4;
  localparam int unsigned GRP_W       = RAW10_PIX_W * PIX_PER_GRP;

  typedef logic [RAW10_PIX_W-1:0] pix_t;
  typedef logic [GRP_W-1:0]       grp_t;
  typedef logic [1:0]             lane_t;

  function automatic pix_t raw10_lane(input grp_t grp, input lane_t idx);
    return grp[GRP_W - 1 - RAW10_PIX_W * int'(idx) -: RAW10_PIX_W];
  endfunction

endpackage

// File: rtl/raw10_grp_fifo.sv
// Synchronous FIFO holding whole pixel groups.
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       synchronous empty; a push in the same cycle lands as the only entry
//   push/wdata  write side; caller guarantees !full or a same-cycle pop
//   pop/rdata   read side; rdata shows the head entry, pop only when !empty
//   full/empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module raw10_grp_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx;

  // After a flush the write pointer restarts at entry 0.
  assign wr_idx = flush ? '0 : wptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rptr_q <= '0;
      wptr_q <= push ? AW'(1) : '0;
      cnt_q  <= push ? (AW+1)'(1) : '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/raw10_pixel_serializer.sv
// Serialises 4-pixel RAW10 groups into a tagged 10-bit pixel stream.
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   frame_start_i   1-cycle pulse: flush everything, restart coordinates
//   grp_valid_i     group strobe (no backpressure upstream)
//   grp_data_i      [39:30]=pix0 (first out) .. [9:0]=pix3
//   pix_valid_o/pix_ready_i/pix_data_o   output pixel stream
//   pix_sof_o/pix_sol_o/pix_eol_o        frame/line markers
//   x_cnt_o, y_cnt_o                     coordinates of the current pixel
//   fifo_full_o     group FIFO holds FIFO_DEPTH groups
//   overflow_o      sticky: a group was dropped since reset/frame start
module raw10_pixel_serializer
  import raw10_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LINE_PIXELS = 1280,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start_i,
  input  logic             grp_valid_i,
  input  logic [39:0]      grp_data_i,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic [9:0]       pix_data_o,
  output logic             pix_sof_o,
  output logic             pix_sol_o,
  output logic             pix_eol_o,
  output logic [CNT_W-1:0] x_cnt_o,
  output logic [CNT_W-1:0] y_cnt_o,
  output logic             fifo_full_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(LINE_PIXELS - 1);

  grp_t             fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             xfer, stage_free, drop;

  grp_t             grp_q;
  lane_t            lane_q;
  logic             valid_q;
  logic [CNT_W-1:0] x_q, y_q;
  logic             sof_pend_q;
  logic             ovf_q;

  assign xfer = valid_q & pix_ready_i;

  // Stage can take a new group when idle or when its last pixel leaves this cycle.
  assign stage_free = ~valid_q | (xfer & (lane_q == lane_t'(PIX_PER_GRP - 1)));
  assign fifo_pop   = ~frame_start_i & ~fifo_empty & stage_free;

  // A full FIFO still accepts when it pops in the same cycle; a flush always frees room.
  assign fifo_push  = grp_valid_i & (frame_start_i | ~fifo_full | fifo_pop);
  assign drop       = grp_valid_i & ~fifo_push;

  raw10_grp_fifo #(
    .WIDTH (GRP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start_i),
    .push  (fifo_push),
    .wdata (grp_data_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q      <= '0;
      lane_q     <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sof_pend_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else if (frame_start_i) begin
      // Partial line is discarded; the stage stays idle until the flushed FIFO refills.
      lane_q     <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sof_pend_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      if (fifo_pop) begin
        grp_q   <= fifo_rdata;
        lane_q  <= '0;
        valid_q <= 1'b1;
      end else if (xfer) begin
        if (lane_q == lane_t'(PIX_PER_GRP - 1)) valid_q <= 1'b0;
        else                                    lane_q  <= lane_q + 2'd1;
      end

      if (xfer) begin
        sof_pend_q <= 1'b0;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + CNT_W'(1);
        end else begin
          x_q <= x_q + CNT_W'(1);
        end
      end

      if (drop) ovf_q <= 1'b1;
    end
  end

  assign pix_valid_o = valid_q;
  assign pix_data_o  = raw10_lane(grp_q, lane_q);
  assign pix_sof_o   = sof_pend_q & valid_q;
  assign pix_sol_o   = (x_q == '0);
  assign pix_eol_o   = (x_q == X_LAST);
  assign x_cnt_o     = x_q;
  assign y_cnt_o     = y_q;
  assign fifo_full_o = fifo_full;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_raw10_pixel_serializer.sv
// Bench for raw10_pixel_serializer with 8-pixel lines and a 4-deep FIFO.
// A table of groups with their expected pixel values feeds a scoreboard; a
// monitor compares every transfer against it.
module tb_raw10_pixel_serializer;

  localparam int unsigned LP    = 8;
  localparam int unsigned CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             grp_valid = 1'b0;
  logic [39:0]      grp_data = '0;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [9:0]       pix_data;
  logic             pix_sof, pix_sol, pix_eol;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic             fifo_full, overflow;

  raw10_pixel_serializer #(
    .FIFO_DEPTH  (4),
    .LINE_PIXELS (LP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .grp_valid_i   (grp_valid),
    .grp_data_i    (grp_data),
    .pix_valid_o   (pix_valid),
    .pix_ready_i   (pix_ready),
    .pix_data_o    (pix_data),
    .pix_sof_o     (pix_sof),
    .pix_sol_o     (pix_sol),
    .pix_eol_o     (pix_eol),
    .x_cnt_o       (x_cnt),
    .y_cnt_o       (y_cnt),
    .fifo_full_o   (fifo_full),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] grp;
    logic [9:0]  pix [4];
  } vec_t;

  typedef struct {
    logic [9:0]       data;
    logic             sof, sol, eol;
    logic [CNT_W-1:0] x, y;
  } exp_t;

  vec_t vecs [4];
  exp_t exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  int               mx = 0;
  int               my = 0;
  logic             msof = 1'b1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_restart();
    exp_q.delete();
    mx   = 0;
    my   = 0;
    msof = 1'b1;
  endtask

  task automatic push_exp(input logic [9:0] d);
    exp_t e;
    e.data = d;
    e.sof  = msof;
    e.sol  = (mx == 0);
    e.eol  = (mx == LP - 1);
    e.x    = CNT_W'(mx);
    e.y    = CNT_W'(my);
    exp_q.push_back(e);
    msof = 1'b0;
    if (mx == LP - 1) begin
      mx = 0;
      my++;
    end else begin
      mx++;
    end
  endtask

  // Present a group this cycle; expected pixels are queued unless it will be dropped.
  task automatic put(input int i, input bit dropped);
    grp_valid = 1'b1;
    grp_data  = vecs[i].grp;
    if (!dropped) for (int p = 0; p < 4; p++) push_exp(vecs[i].pix[p]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!pix_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", 40'(pix_valid), 40'(1));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 40'(exp_q.size()), 40'(0));
  endtask

  // Scoreboard monitor: sampled on the falling edge, ahead of the transfer edge.
  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 40'(pix_data), 40'h3ff_dead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pix_data", 40'(pix_data), 40'(e.data));
        check("pix_sof",  40'(pix_sof),  40'(e.sof));
        check("pix_sol",  40'(pix_sol),  40'(e.sol));
        check("pix_eol",  40'(pix_eol),  40'(e.eol));
        check("x_cnt",    40'(x_cnt),    40'(e.x));
        check("y_cnt",    40'(y_cnt),    40'(e.y));
      end
    end
  end

  initial begin
    vecs[0].grp = 40'h00_4020_0C04;
    vecs[0].pix = '{10'h001, 10'h002, 10'h003, 10'h004};
    vecs[1].grp = 40'hFF_C005_56AA;
    vecs[1].pix = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
    vecs[2].grp = 40'h48_C45F_000F;
    vecs[2].pix = '{10'h123, 10'h045, 10'h3C0, 10'h00F};
    vecs[3].grp = 40'h80_1112_AFFE;
    vecs[3].pix = '{10'h200, 10'h111, 10'h0AB, 10'h3FE};

    // Reset state
    repeat (2) tick();
    check("rst_valid", 40'(pix_valid), 40'(0));
    check("rst_data",  40'(pix_data),  40'(0));
    check("rst_sof",   40'(pix_sof),   40'(0));
    check("rst_sol",   40'(pix_sol),   40'(1));
    check("rst_eol",   40'(pix_eol),   40'(0));
    check("rst_x",     40'(x_cnt),     40'(0));
    check("rst_y",     40'(y_cnt),     40'(0));
    check("rst_full",  40'(fifo_full), 40'(0));
    check("rst_ovf",   40'(overflow),  40'(0));
    rst_n = 1'b1;
    tick();

    // 1: single group, latency and first-pixel markers
    pix_ready = 1'b1;
    put(0, 1'b0);
    tick();
    grp_valid = 1'b0;
    check("t1_lat_k",   40'(pix_valid), 40'(0));
    tick();
    check("t1_lat_k1",  40'(pix_valid), 40'(1));
    check("t1_sof",     40'(pix_sof),   40'(1));
    check("t1_sol",     40'(pix_sol),   40'(1));
    drain(20);

    // 2/3: four groups every 4 cycles, two full lines, no bubbles
    frame_start = 1'b1;
    model_restart();
    tick();
    frame_start = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          put(i, 1'b0);
          tick();
          grp_valid = 1'b0;
          repeat (3) tick();
        end
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!pix_valid && n < 10) begin
          @(negedge clk);
          n++;
        end
        for (int c = 0; c < 16; c++) begin
          check("t2_no_bubble", 40'(pix_valid), 40'(1));
          @(negedge clk);
        end
      end
    join
    drain(20);
    check("t2_ovf", 40'(overflow), 40'(0));
    check("t3_x",   40'(x_cnt),    40'(0));
    check("t3_y",   40'(y_cnt),    40'(2));

    // 4: stalled output, fill FIFO, then overflow
    pix_ready = 1'b0;
    put(0, 1'b0); tick();
    put(1, 1'b0); tick();
    put(2, 1'b0); tick();
    put(3, 1'b0); tick();
    put(0, 1'b0); tick();
    grp_valid = 1'b0;
    check("t4_full",     40'(fifo_full), 40'(1));
    check("t4_no_ovf",   40'(overflow),  40'(0));
    put(1, 1'b1); tick();
    grp_valid = 1'b0;
    check("t4_ovf",      40'(overflow),  40'(1));
    check("t4_full2",    40'(fifo_full), 40'(1));
    tick();
    check("t4_sticky",   40'(overflow),  40'(1));
    pix_ready = 1'b1;
    drain(40);
    check("t4_sticky2",  40'(overflow),  40'(1));
    check("t4_not_full", 40'(fifo_full), 40'(0));

    // 5: stall mid-group holds data and coordinates
    put(2, 1'b0);
    tick();
    grp_valid = 1'b0;
    wait_valid(10);
    tick();
    pix_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_hold_data", 40'(pix_data), 40'(exp_q[0].data));
      check("t5_hold_x",    40'(x_cnt),    40'(exp_q[0].x));
    end
    pix_ready = 1'b1;
    drain(20);

    // 6: frame start mid-line with a coincident group
    put(0, 1'b0); tick();
    put(1, 1'b0); tick();
    grp_valid = 1'b0;
    wait_valid(10);
    tick();
    tick();
    pix_ready   = 1'b0;
    frame_start = 1'b1;
    model_restart();
    put(3, 1'b0);
    tick();
    frame_start = 1'b0;
    grp_valid   = 1'b0;
    check("t6_valid", 40'(pix_valid), 40'(0));
    check("t6_x",     40'(x_cnt),     40'(0));
    check("t6_y",     40'(y_cnt),     40'(0));
    check("t6_ovf",   40'(overflow),  40'(0));
    pix_ready = 1'b1;
    drain(20);
    check("t6_x_end", 40'(x_cnt), 40'(4));

    // 7: asynchronous reset mid-line
    put(2, 1'b0); tick();
    put(3, 1'b0); tick();
    grp_valid = 1'b0;
    wait_valid(10);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    model_restart();
    #1;
    check("t7_valid", 40'(pix_valid), 40'(0));
    check("t7_data",  40'(pix_data),  40'(0));
    check("t7_sof",   40'(pix_sof),   40'(0));
    check("t7_sol",   40'(pix_sol),   40'(1));
    check("t7_x",     40'(x_cnt),     40'(0));
    check("t7_y",     40'(y_cnt),     40'(0));
    check("t7_full",  40'(fifo_full), 40'(0));
    check("t7_ovf",   40'(overflow),  40'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t7_empty", 40'(pix_valid), 40'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
